mem_bus_arbiter: RTL and testbench
==================================

Name: mem_bus_arbiter

Overview:
- Shares the single 8-bit data memory between two requesters: port 0 (processor load/store path) and port 1 (auxiliary master, e.g. I/O loader or DMA).
- Serialises accesses, drives the memory's one-cycle read/write strobes and routes read data back to the winning port.
- Round-robin arbitration; sits between the requesters and the data memory in the processor top level.

Parameters:
- AW, 8, address width.
- DW, 8, data width.
- RD_LAT, 1, cycles from read strobe to valid mem_rdata (must be >= 1).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- req_0 / req_1  in  1  access request; held until gnt of the same port.
- we_0 / we_1  in  1  1 = write, 0 = read; valid while req.
- addr_0 / addr_1  in  AW  access address; valid while req.
- wdata_0 / wdata_1  in  DW  write data; valid while req and we.
- gnt_0 / gnt_1  out  1  one-cycle pulse; access issued to memory this cycle.
- rvalid_0 / rvalid_1  out  1  one-cycle pulse; rdata_x holds read result.
- rdata_0 / rdata_1  out  DW  registered read data, held until next read of that port.
- busy  out  1  high whenever state != IDLE.
- mem_addr  out  AW  memory address.
- mem_wdata  out  DW  memory write data.
- M_read  out  1  memory read strobe, one cycle per read.
- M_write  out  1  memory write strobe, one cycle per write.
- mem_rdata  in  DW  memory read data, valid RD_LAT cycles after M_read.

Behaviour:
- Reset: state=IDLE, all gnt/rvalid/M_read/M_write/busy = 0, rdata_x/mem_addr/mem_wdata = 0, last_gnt = 1 so port 0 wins the first tie.
- FSM has three states: IDLE, ACCESS, RD_WAIT.
- IDLE with no req: remain in IDLE.
- IDLE with a single req: that port wins.
- IDLE with both req: winner is the port != last_gnt.
- On a win in IDLE: latch winner's addr/wdata/we and index, update last_gnt, go to ACCESS.
- ACCESS lasts exactly one cycle:
  - gnt_winner = 1 and mem_addr/mem_wdata are driven from the latched values.
  - M_write = latched we; M_read = !latched we.
  - A write goes to IDLE; a read goes to RD_WAIT with counter = RD_LAT.
- RD_WAIT: decrement the counter each cycle. At the cycle mem_rdata is valid (strobe cycle + RD_LAT), register it into rdata_winner. rvalid_winner pulses the following cycle, then the FSM returns to IDLE.
- Latency, with req first sampled in cycle T (IDLE):
  - gnt and strobe in T+1.
  - Read rvalid in T+2+RD_LAT.
  - Next arbitration decision no earlier than T+2 (write) or T+2+RD_LAT (read).
  - Back-to-back write throughput is one every 2 cycles.
- Requester rules: req must be held until gnt. req still high in the IDLE cycle after the access completes counts as a new request.
- The losing request is never dropped; it wins the next arbitration. Starvation bound is one access of the other port.
- Output isolation: rvalid/gnt never both asserted to different ports in one cycle. The non-winning port's outputs stay 0.
- mem_addr/mem_wdata hold their last value outside ACCESS. Strobes are 0 outside ACCESS.
- Reset in any state wins: it returns to IDLE next cycle and drops an in-flight read silently (no rvalid). rdata_x is cleared.
- Inputs that change on a port not currently in ACCESS have no effect on memory outputs.

Optional Feature:
- Macro: MEM_ARB_LOCK_EN.
- With the macro: adds inputs lock_0 / lock_1 (1 bit).
  - If the port in ACCESS has lock high, a lock flag is set.
  - Next IDLE arbitration then considers only that port; the other port waits.
  - The flag clears when the locked port's access completes with lock low, when the locked port shows no req in IDLE, or on reset.
  - Enables atomic read-modify-write.
- Without the macro: lock ports do not exist and arbitration is pure round-robin.

Decomposition:
- Shared package holds:
  - the state encoding constants (IDLE=2'd0, ACCESS=2'd1, RD_WAIT=2'd2);
  - port index constants PORT_CPU=0, PORT_AUX=1;
  - default widths AW/DW.
- One natural sub-module: rr_pick2 (combinational two-way round-robin picker). Inputs: req_0, req_1, last_gnt, optional lock mask. Outputs: any, winner index.

Test Plan:
- Single write: req_0=1, we_0=1, addr_0=8'h10, wdata_0=8'hA5 -> next cycle gnt_0=1, M_write=1, mem_addr=8'h10, mem_wdata=8'hA5; busy drops after 1 cycle.
- Single read, RD_LAT=1: memory returns 8'h3C for addr_1=8'h20 -> M_read in T+1, rvalid_1=1 with rdata_1=8'h3C in T+3, rvalid_0 stays 0.
- Simultaneous req_0 and req_1 writes after reset -> port 0 granted first, port 1 granted 2 cycles later. Repeating the tie gives strict alternation 0,1,0,1.
- Reset asserted during RD_WAIT -> no rvalid, state IDLE, M_read/M_write 0, rdata_x = 0; next request is served normally.
- With MEM_ARB_LOCK_EN: port 0 read with lock_0=1 while req_1 pending, then port 0 write with lock_0=0 -> both port-0 accesses complete before gnt_1. Without the macro, gnt_1 falls between them.

Source files
------------

// File: rtl/mem_bus_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// mem_bus_arbiter_pkg
// Shared constants for the two-port data-memory arbiter:
//   - FSM state encoding (IDLE / ACCESS / RD_WAIT)
//   - requester port indices (CPU load/store path, auxiliary master)
//   - default address / data widths
// ---------------------------------------------------------------------------
package mem_bus_arbiter_pkg;

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] ACCESS  = 2'd1;
    localparam logic [1:0] RD_WAIT = 2'd2;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_AUX = 1'b1;

    localparam int DEF_AW = 8;
    localparam int DEF_DW = 8;

endpackage

// File: rtl/mem_bus_arbiter_rr_pick2.sv
// ---------------------------------------------------------------------------
// mem_bus_arbiter_rr_pick2
// Combinational two-way round-robin picker.
//   i_req_0, i_req_1 : requests
//   i_last_gnt       : index of the port granted most recently
//   i_lock_en        : when high only i_lock_port may win
//   i_lock_port      : port that owns the lock
//   o_any            : at least one eligible request
//   o_winner         : index of the winning port (valid when o_any)
// ---------------------------------------------------------------------------
module mem_bus_arbiter_rr_pick2
    import mem_bus_arbiter_pkg::*;
(
    input  logic i_req_0,
    input  logic i_req_1,
    input  logic i_last_gnt,
    input  logic i_lock_en,
    input  logic i_lock_port,
    output logic o_any,
    output logic o_winner
);

    logic w_req_0;
    logic w_req_1;

    always_comb begin
        // A held lock masks out the port that does not own it.
        w_req_0  = i_req_0 & ~(i_lock_en & (i_lock_port == PORT_AUX));
        w_req_1  = i_req_1 & ~(i_lock_en & (i_lock_port == PORT_CPU));
        o_any    = w_req_0 | w_req_1;
        o_winner = PORT_CPU;
        if (w_req_0 && w_req_1) begin
            o_winner = ~i_last_gnt;
        end else if (w_req_1) begin
            o_winner = PORT_AUX;
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// ---------------------------------------------------------------------------
// mem_bus_arbiter
// Shares one data memory between port 0 (CPU load/store) and port 1
// (auxiliary master). Round-robin arbitration, one access at a time.
//
// Parameters: AW address width, DW data width, RD_LAT read latency (>= 1).
//
// Ports:
//   clk, reset              clock, synchronous active-high reset
//   req_x, we_x, addr_x,    per-port request, direction, address,
//   wdata_x                 write data (held until gnt_x)
//   gnt_x                   one-cycle pulse, access issued this cycle
//   rvalid_x, rdata_x       read-return pulse and registered read data
//   busy                    FSM not in IDLE
//   mem_addr, mem_wdata     memory address / write data (hold outside ACCESS)
//   M_read, M_write         one-cycle memory strobes
//   mem_rdata               memory read data, valid RD_LAT after M_read
//
// Optional build macro MEM_ARB_LOCK_EN adds lock_0 / lock_1 inputs: a port
// whose access carries lock keeps exclusive ownership of the next
// arbitration, enabling atomic read-modify-write sequences.
// ---------------------------------------------------------------------------
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int AW     = DEF_AW,
    parameter int DW     = DEF_DW,
    parameter int RD_LAT = 1
)
(
    input  logic          clk,
    input  logic          reset,
    input  logic          req_0,
    input  logic          req_1,
    input  logic          we_0,
    input  logic          we_1,
    input  logic [AW-1:0] addr_0,
    input  logic [AW-1:0] addr_1,
    input  logic [DW-1:0] wdata_0,
    input  logic [DW-1:0] wdata_1,
`ifdef MEM_ARB_LOCK_EN
    input  logic          lock_0,
    input  logic          lock_1,
`endif
    output logic          gnt_0,
    output logic          gnt_1,
    output logic          rvalid_0,
    output logic          rvalid_1,
    output logic [DW-1:0] rdata_0,
    output logic [DW-1:0] rdata_1,
    output logic          busy,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          M_read,
    output logic          M_write,
    input  logic [DW-1:0] mem_rdata
);

    localparam int CW = (RD_LAT < 1) ? 1 : $clog2(RD_LAT + 1);

    logic [1:0]    r_state;
    logic          r_idx;
    logic          r_last_gnt;
    logic          r_we;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_wdata;
    logic [CW-1:0] r_cnt;
    logic          r_rvalid_0;
    logic          r_rvalid_1;
    logic [DW-1:0] r_rdata_0;
    logic [DW-1:0] r_rdata_1;

    logic          w_any;
    logic          w_winner;
    logic          w_lock_en;
    logic          w_lock_port;
    logic          w_access;

`ifdef MEM_ARB_LOCK_EN
    logic          r_lock;
    logic          r_lock_port;
    logic          r_lock_req;
    logic          w_lock_port_req;

    // The lock only binds while its owner is still asking for the bus.
    assign w_lock_port_req = (r_lock_port == PORT_AUX) ? req_1 : req_0;
    assign w_lock_en       = r_lock & w_lock_port_req;
    assign w_lock_port     = r_lock_port;
`else
    assign w_lock_en       = 1'b0;
    assign w_lock_port     = PORT_CPU;
`endif

    mem_bus_arbiter_rr_pick2 u_pick (
        .i_req_0     (req_0),
        .i_req_1     (req_1),
        .i_last_gnt  (r_last_gnt),
        .i_lock_en   (w_lock_en),
        .i_lock_port (w_lock_port),
        .o_any       (w_any),
        .o_winner    (w_winner)
    );

    // Strobes and grants are decoded from the state so they can only be
    // high during the single ACCESS cycle, and only for the latched winner.
    assign w_access  = (r_state == ACCESS);
    assign gnt_0     = w_access & (r_idx == PORT_CPU);
    assign gnt_1     = w_access & (r_idx == PORT_AUX);
    assign M_write   = w_access & r_we;
    assign M_read    = w_access & ~r_we;
    assign busy      = (r_state != IDLE);
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign rvalid_0  = r_rvalid_0;
    assign rvalid_1  = r_rvalid_1;
    assign rdata_0   = r_rdata_0;
    assign rdata_1   = r_rdata_1;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_idx      <= PORT_CPU;
            r_last_gnt <= PORT_AUX;  // port 0 wins the first tie
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_cnt      <= '0;
            r_rvalid_0 <= 1'b0;
            r_rvalid_1 <= 1'b0;
            r_rdata_0  <= '0;
            r_rdata_1  <= '0;
`ifdef MEM_ARB_LOCK_EN
            r_lock      <= 1'b0;
            r_lock_port <= PORT_CPU;
            r_lock_req  <= 1'b0;
`endif
        end else begin
            r_rvalid_0 <= 1'b0;
            r_rvalid_1 <= 1'b0;
            case (r_state)
                IDLE: begin
`ifdef MEM_ARB_LOCK_EN
                    if (r_lock && !w_lock_port_req) begin
                        r_lock <= 1'b0;
                    end
`endif
                    if (w_any) begin
                        r_idx      <= w_winner;
                        r_last_gnt <= w_winner;
                        r_we       <= (w_winner == PORT_AUX) ? we_1    : we_0;
                        r_addr     <= (w_winner == PORT_AUX) ? addr_1  : addr_0;
                        r_wdata    <= (w_winner == PORT_AUX) ? wdata_1 : wdata_0;
`ifdef MEM_ARB_LOCK_EN
                        r_lock_req <= (w_winner == PORT_AUX) ? lock_1  : lock_0;
`endif
                        r_state    <= ACCESS;
                    end
                end
                ACCESS: begin
`ifdef MEM_ARB_LOCK_EN
                    // Lock is (re)armed or released by each access of its owner.
                    r_lock      <= r_lock_req;
                    r_lock_port <= r_idx;
`endif
                    if (r_we) begin
                        r_state <= IDLE;
                    end else begin
                        r_cnt   <= CW'(RD_LAT);
                        r_state <= RD_WAIT;
                    end
                end
                RD_WAIT: begin
                    // Count reaches 1 in the cycle mem_rdata is valid.
                    if (r_cnt == CW'(1)) begin
                        if (r_idx == PORT_AUX) begin
                            r_rdata_1  <= mem_rdata;
                            r_rvalid_1 <= 1'b1;
                        end else begin
                            r_rdata_0  <= mem_rdata;
                            r_rvalid_0 <= 1'b1;
                        end
                        r_state <= IDLE;
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_bus_arbiter
// Directed self-checking bench for mem_bus_arbiter (RD_LAT = 1) with a small
// single-cycle-latency memory model. Honours MEM_ARB_LOCK_EN when defined.
// ---------------------------------------------------------------------------
module tb_mem_bus_arbiter;

    logic       clk;
    logic       reset;
    logic       req_0, req_1;
    logic       we_0, we_1;
    logic [7:0] addr_0, addr_1;
    logic [7:0] wdata_0, wdata_1;
`ifdef MEM_ARB_LOCK_EN
    logic       lock_0, lock_1;
`endif
    logic       gnt_0, gnt_1;
    logic       rvalid_0, rvalid_1;
    logic [7:0] rdata_0, rdata_1;
    logic       busy;
    logic [7:0] mem_addr, mem_wdata;
    logic       M_read, M_write;
    logic [7:0] mem_rdata;

    logic [7:0] mem [0:255];

    int checks = 0;
    int errors = 0;

    mem_bus_arbiter #(.AW(8), .DW(8), .RD_LAT(1)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_0     (req_0),
        .req_1     (req_1),
        .we_0      (we_0),
        .we_1      (we_1),
        .addr_0    (addr_0),
        .addr_1    (addr_1),
        .wdata_0   (wdata_0),
        .wdata_1   (wdata_1),
`ifdef MEM_ARB_LOCK_EN
        .lock_0    (lock_0),
        .lock_1    (lock_1),
`endif
        .gnt_0     (gnt_0),
        .gnt_1     (gnt_1),
        .rvalid_0  (rvalid_0),
        .rvalid_1  (rvalid_1),
        .rdata_0   (rdata_0),
        .rdata_1   (rdata_1),
        .busy      (busy),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .M_read    (M_read),
        .M_write   (M_write),
        .mem_rdata (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: preloaded during reset, one-cycle read latency.
    always @(posedge clk) begin
        if (reset) begin
            mem[8'h20] <= 8'h3C;
            mem[8'h40] <= 8'h77;
            mem[8'h41] <= 8'h5A;
        end else begin
            if (M_write) mem[mem_addr] <= mem_wdata;
            if (M_read)  mem_rdata <= mem[mem_addr];
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1;
        req_0 = 1'b0; req_1 = 1'b0; we_0 = 1'b0; we_1 = 1'b0;
        addr_0 = 8'h00; addr_1 = 8'h00; wdata_0 = 8'h00; wdata_1 = 8'h00;
`ifdef MEM_ARB_LOCK_EN
        lock_0 = 1'b0; lock_1 = 1'b0;
`endif
        tick(); tick();

        // Reset state
        chk("rst_busy", busy, 0);
        chk("rst_gnt0", gnt_0, 0);
        chk("rst_gnt1", gnt_1, 0);
        chk("rst_mread", M_read, 0);
        chk("rst_mwrite", M_write, 0);
        chk("rst_rvalid0", rvalid_0, 0);
        chk("rst_rvalid1", rvalid_1, 0);
        chk("rst_rdata0", rdata_0, 0);
        chk("rst_rdata1", rdata_1, 0);
        chk("rst_maddr", mem_addr, 0);
        chk("rst_mwdata", mem_wdata, 0);
        reset = 1'b0;

        // Single write on port 0
        req_0 = 1'b1; we_0 = 1'b1; addr_0 = 8'h10; wdata_0 = 8'hA5;
        tick();
        chk("wr_gnt0", gnt_0, 1);
        chk("wr_gnt1", gnt_1, 0);
        chk("wr_mwrite", M_write, 1);
        chk("wr_mread", M_read, 0);
        chk("wr_maddr", mem_addr, 8'h10);
        chk("wr_mwdata", mem_wdata, 8'hA5);
        chk("wr_busy", busy, 1);
        req_0 = 1'b0;
        tick();
        chk("wr_busy_drop", busy, 0);
        chk("wr_mwrite_off", M_write, 0);
        chk("wr_gnt0_off", gnt_0, 0);
        chk("wr_maddr_hold", mem_addr, 8'h10);

        // Single read on port 1
        req_1 = 1'b1; we_1 = 1'b0; addr_1 = 8'h20;
        tick();
        chk("rd1_gnt1", gnt_1, 1);
        chk("rd1_gnt0", gnt_0, 0);
        chk("rd1_mread", M_read, 1);
        chk("rd1_mwrite", M_write, 0);
        chk("rd1_maddr", mem_addr, 8'h20);
        req_1 = 1'b0;
        tick();
        chk("rd1_wait_busy", busy, 1);
        chk("rd1_wait_mread", M_read, 0);
        chk("rd1_wait_rvalid", rvalid_1, 0);
        tick();
        chk("rd1_rvalid1", rvalid_1, 1);
        chk("rd1_rdata1", rdata_1, 8'h3C);
        chk("rd1_rvalid0", rvalid_0, 0);
        chk("rd1_busy", busy, 0);
        tick();
        chk("rd1_rvalid1_pulse", rvalid_1, 0);
        chk("rd1_rdata1_hold", rdata_1, 8'h3C);

        // Read back the earlier write through port 0
        req_0 = 1'b1; we_0 = 1'b0; addr_0 = 8'h10;
        tick();
        chk("rb_gnt0", gnt_0, 1);
        req_0 = 1'b0;
        tick(); tick();
        chk("rb_rvalid0", rvalid_0, 1);
        chk("rb_rdata0", rdata_0, 8'hA5);
        chk("rb_rvalid1", rvalid_1, 0);

        // Tie after reset: strict alternation 0,1,0,1
        reset = 1'b1; tick(); reset = 1'b0;
        chk("tie_rst_rdata0", rdata_0, 0);
        chk("tie_rst_rdata1", rdata_1, 0);
        req_0 = 1'b1; we_0 = 1'b1; addr_0 = 8'h30; wdata_0 = 8'h11;
        req_1 = 1'b1; we_1 = 1'b1; addr_1 = 8'h31; wdata_1 = 8'h22;
        tick();
        chk("tie1_gnt0", gnt_0, 1);
        chk("tie1_gnt1", gnt_1, 0);
        chk("tie1_maddr", mem_addr, 8'h30);
        tick();
        chk("tie_gap_busy", busy, 0);
        chk("tie_gap_gnt0", gnt_0, 0);
        chk("tie_gap_gnt1", gnt_1, 0);
        tick();
        chk("tie2_gnt1", gnt_1, 1);
        chk("tie2_gnt0", gnt_0, 0);
        chk("tie2_maddr", mem_addr, 8'h31);
        chk("tie2_mwdata", mem_wdata, 8'h22);
        tick(); tick();
        chk("tie3_gnt0", gnt_0, 1);
        chk("tie3_gnt1", gnt_1, 0);
        tick(); tick();
        chk("tie4_gnt1", gnt_1, 1);
        chk("tie4_gnt0", gnt_0, 0);
        req_0 = 1'b0; req_1 = 1'b0;
        tick();
        chk("tie_end_busy", busy, 0);

        // Reset during RD_WAIT drops the read and clears rdata
        req_0 = 1'b1; we_0 = 1'b0; addr_0 = 8'h40;
        tick();
        chk("pre_gnt0", gnt_0, 1);
        req_0 = 1'b0;
        tick(); tick();
        chk("pre_rvalid0", rvalid_0, 1);
        chk("pre_rdata0", rdata_0, 8'h77);
        tick();
        req_0 = 1'b1; addr_0 = 8'h41;
        tick();
        chk("abort_gnt0", gnt_0, 1);
        chk("abort_mread", M_read, 1);
        req_0 = 1'b0;
        tick();
        chk("abort_wait_busy", busy, 1);
        reset = 1'b1;
        tick();
        chk("abort_busy", busy, 0);
        chk("abort_rvalid0", rvalid_0, 0);
        chk("abort_rdata0", rdata_0, 0);
        chk("abort_mread_off", M_read, 0);
        chk("abort_mwrite_off", M_write, 0);
        reset = 1'b0;
        tick();
        chk("abort_no_late_rvalid", rvalid_0, 0);
        chk("abort_idle_busy", busy, 0);
        req_1 = 1'b1; we_1 = 1'b0; addr_1 = 8'h20;
        tick();
        chk("post_gnt1", gnt_1, 1);
        req_1 = 1'b0;
        tick(); tick();
        chk("post_rvalid1", rvalid_1, 1);
        chk("post_rdata1", rdata_1, 8'h3C);

        // Lock: port 0 read (lock) then write (unlock) with port 1 pending
        reset = 1'b1; tick(); reset = 1'b0;
        req_0 = 1'b1; we_0 = 1'b0; addr_0 = 8'h20;
        req_1 = 1'b1; we_1 = 1'b1; addr_1 = 8'h50; wdata_1 = 8'h99;
`ifdef MEM_ARB_LOCK_EN
        lock_0 = 1'b1;
`endif
        tick();
        chk("lk_rd_gnt0", gnt_0, 1);
        chk("lk_rd_mread", M_read, 1);
        we_0 = 1'b1; addr_0 = 8'h21; wdata_0 = 8'h55;
`ifdef MEM_ARB_LOCK_EN
        lock_0 = 1'b0;
`endif
        tick();
        chk("lk_wait_gnt1", gnt_1, 0);
        tick();
        chk("lk_rvalid0", rvalid_0, 1);
        chk("lk_rdata0", rdata_0, 8'h3C);
        chk("lk_idle_gnt1", gnt_1, 0);
        tick();
`ifdef MEM_ARB_LOCK_EN
        chk("lk_wr_gnt0", gnt_0, 1);
        chk("lk_wr_gnt1", gnt_1, 0);
        chk("lk_wr_maddr", mem_addr, 8'h21);
        chk("lk_wr_mwdata", mem_wdata, 8'h55);
        req_0 = 1'b0;
        tick(); tick();
        chk("lk_then_gnt1", gnt_1, 1);
        chk("lk_then_maddr", mem_addr, 8'h50);
        req_1 = 1'b0;
`else
        chk("rr_gnt1", gnt_1, 1);
        chk("rr_gnt0", gnt_0, 0);
        chk("rr_maddr", mem_addr, 8'h50);
        chk("rr_mwdata", mem_wdata, 8'h99);
        req_1 = 1'b0;
        tick(); tick();
        chk("rr_then_gnt0", gnt_0, 1);
        chk("rr_then_maddr", mem_addr, 8'h21);
        req_0 = 1'b0;
`endif
        tick();
        chk("end_busy", busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
